ftoi_arbiter: RTL and testbench

FTOI_ARBITER -- requirements
Module: ftoi_arbiter

---
 rtl/ftoi_arbiter.sv | 128 ++++++++++++
 tb/tb_ftoi_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftoi_arbiter.sv
// ftoi_arbiter: round-robin arbiter in front of a shared float-to-int converter.
// NREQ requesters offer IEEE-754 single operands; one winner is accepted in
// IDLE, converted in CONV (round-half-away-from-zero, saturating to
// +/-0x7FFFFFFF), and presented in RESP until the consumer takes it.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/req_data per-requester operand offer (32 bits per requester)
//   req_ready          one-hot accept, combinational from req_valid in IDLE
//   resp_valid/id/data registered result with owning requester index
//   resp_ready         consumer accept
//   busy               FSM not idle
//   done_count         wrapping count of completed response handshakes
module ftoi_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic [15:0]          done_count
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [DW-1:0]   operand;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [DW-1:0]   conv_result;

  logic [7:0]      exp_f;
  logic [DW-1:0]   mant;
  logic [DW-1:0]   mag;
  logic [4:0]      rnd_pos;
  logic            rnd_bit;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req_valid[IDW'(idx)]) begin
        grant_any             = 1'b1;
        grant_idx             = IDW'(idx);
        grant[IDW'(idx)]      = 1'b1;
      end
    end
  end

  // Grant is only offered while idle and out of reset.
  assign req_ready  = (state == IDLE && !rst) ? grant : '0;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Float-to-int conversion of the latched operand.
  always_comb begin
    exp_f   = operand[30:23];
    mant    = {8'd0, 1'b1, operand[22:0]};
    mag     = '0;
    rnd_pos = '0;
    rnd_bit = 1'b0;
    if (exp_f < 8'd126) begin
      mag = '0;
    end else if (exp_f > 8'd157) begin
      mag = 32'h7FFF_FFFF;
    end else if (exp_f > 8'd149) begin
      mag = mant << (exp_f - 8'd150);
    end else begin
      // The bit just below the integer LSB decides round-half-away.
      rnd_pos = 5'(8'd149 - exp_f);
      rnd_bit = mant[rnd_pos];
      mag     = (mant >> (8'd150 - exp_f)) + DW'(rnd_bit);
    end
    conv_result = operand[31] ? (~mag + DW'(1)) : mag;
  end

  // Control FSM with registered result, id, pointer and completion count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      operand    <= '0;
      resp_id    <= '0;
      resp_data  <= '0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            operand <= req_data[DW*grant_idx +: DW];
            resp_id <= grant_idx;
            ptr     <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
            state   <= CONV;
          end
        end
        CONV: begin
          resp_data <= conv_result;
          state     <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            done_count <= done_count + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ftoi_arbiter.sv
// Testbench for ftoi_arbiter: real-arithmetic reference model plus a
// per-cycle compare process, driven by directed vectors with literal results.
module tb_ftoi_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [31:0]         resp_data;
  logic                resp_ready;
  logic                busy;
  logic [15:0]         done_count;

  always #5 clk = ~clk;

  ftoi_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy), .done_count(done_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion using real arithmetic on the float's value.
  function automatic logic [31:0] model_ftoi(input logic [31:0] f);
    int     e;
    real    v;
    longint p;
    e = int'(f[30:23]);
    if (e < 126) p = 0;
    else if (e > 157) p = 64'h7FFF_FFFF;
    else begin
      v = real'(int'({1'b1, f[22:0]}));
      for (int k = 150; k < e; k++) v = v * 2.0;
      for (int k = e; k < 150; k++) v = v / 2.0;
      p = longint'($rtoi(v + 0.5));
    end
    return f[31] ? 32'(-p) : 32'(p);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] slot(input logic [32*NREQ-1:0] d, input int i);
    return d[i*32 +: 32];
  endfunction

  // Model: one outstanding job with an age since acceptance.
  int          m_ptr  = 0;
  bit          m_pend = 0;
  int          m_age  = 0;
  int          m_id   = 0;
  logic [31:0] m_op   = '0;
  logic [31:0] m_data = '0;
  logic [15:0] m_cnt  = '0;
  bit          preload = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr <= 0; m_pend <= 0; m_age <= 0; m_id <= 0; m_data <= '0; m_cnt <= '0;
    end else begin
      if (preload) m_cnt <= 16'hFFFE;
      if (!m_pend) begin
        if (rr_pick(req_valid, m_ptr) >= 0) begin
          m_pend <= 1;
          m_age  <= 1;
          m_id   <= rr_pick(req_valid, m_ptr);
          m_op   <= slot(req_data, rr_pick(req_valid, m_ptr));
          m_ptr  <= (rr_pick(req_valid, m_ptr) + 1) % NREQ;
        end
      end else if (m_age == 1) begin
        m_age  <= 2;
        m_data <= model_ftoi(m_op);
      end else if (resp_ready) begin
        m_pend <= 0;
        m_cnt  <= m_cnt + 16'd1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    logic [NREQ-1:0] exp_rdy;
    int pk;
    @(negedge clk);
    exp_rdy = '0;
    if (!rst && !m_pend) begin
      pk = rr_pick(req_valid, m_ptr);
      if (pk >= 0) exp_rdy[pk] = 1'b1;
    end
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    check("resp_valid", 32'(resp_valid), 32'(!rst && m_pend && m_age >= 2));
    check("busy", 32'(busy), 32'(m_pend));
    check("done_count", 32'(done_count), 32'(m_cnt));
    if (rst) begin
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
    end else if (m_pend && m_age >= 2) begin
      check("resp_data", resp_data, m_data);
      check("resp_id", 32'(resp_id), 32'(m_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single request: accept at next edge, result two edges later, then handshake.
  task automatic run_one(input int idx, input logic [31:0] op, input logic [31:0] exp,
                         input logic [15:0] exp_cnt);
    req_data[idx*32 +: 32] = op;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    tick();
    req_valid = '0;
    @(negedge clk);
    check("lat_conv_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("lat_resp_valid", 32'(resp_valid), 32'd1);
    check("lit_resp_data", resp_data, exp);
    check("lit_resp_id", 32'(resp_id), 32'(idx));
    tick();
    check("lit_done_count", 32'(done_count), 32'(exp_cnt));
    check("lit_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int ids[$];
    int cycs[$];
    logic [31:0] held_data;
    logic [IDW-1:0] held_id;

    req_valid  = '1;
    req_data   = '0;
    resp_ready = 1'b1;

    // Literal pins on the reference conversion.
    check("model_1p5", model_ftoi(32'h3FC00000), 32'h00000002);
    check("model_m2p5", model_ftoi(32'hC0200000), 32'hFFFFFFFD);
    check("model_0p4", model_ftoi(32'h3ECCCCCD), 32'h00000000);
    check("model_3e9", model_ftoi(32'h4F32D05E), 32'h7FFFFFFF);
    check("model_ninf", model_ftoi(32'hFF800000), 32'h80000001);

    // Reset with all requesters valid: nothing granted.
    tick(); tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_count), 32'd0);
    tick();
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Directed conversions, including rounding and saturation boundaries.
    run_one(0, 32'h3FC00000, 32'h00000002, 16'd1);
    run_one(2, 32'hC0200000, 32'hFFFFFFFD, 16'd2);
    run_one(1, 32'h3ECCCCCD, 32'h00000000, 16'd3);
    run_one(3, 32'h4F32D05E, 32'h7FFFFFFF, 16'd4);
    run_one(0, 32'hFF800000, 32'h80000001, 16'd5);
    run_one(1, 32'h3F000000, 32'h00000001, 16'd6);
    run_one(2, 32'hBF000000, 32'hFFFFFFFF, 16'd7);
    run_one(3, 32'h4EFFFFFF, 32'h7FFFFF80, 16'd8);
    run_one(0, 32'h3EFFFFFF, 32'h00000000, 16'd9);

    // Round-robin from reset with all requesters valid.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*32 +: 32] = 32'h3F800000 + 32'(i << 23);
    req_valid = '1;
    for (int t = 0; t < 60 && ids.size() < 12; t++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin ids.push_back(i); cycs.push_back(t); end
    end
    tick();
    req_valid = '0;
    check("rr_count", 32'(ids.size()), 32'd12);
    for (int k = 0; k < ids.size(); k++) begin
      check("rr_id", 32'(ids[k]), 32'(k % 4));
      if (k > 0) check("rr_interval", 32'(cycs[k] - cycs[k-1]), 32'd3);
    end
    tick(); tick(); tick();

    // Backpressure: result held, no grants while waiting.
    resp_ready = 1'b0;
    req_data[1*32 +: 32] = 32'h40490FDB;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    req_valid = '1;
    held_data = resp_data;
    held_id   = resp_id;
    check("bp_data", held_data, 32'h00000003);
    check("bp_id", 32'(held_id), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_stable_data", resp_data, held_data);
      check("bp_stable_id", 32'(resp_id), 32'(held_id));
      check("bp_no_ready", 32'(req_ready), 32'd0);
      check("bp_done", 32'(done_count), 32'd12);
    end
    resp_ready = 1'b1;
    tick();
    req_valid = '0;
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_done_after", 32'(done_count), 32'd13);
    tick();

    // Reset one cycle into CONV aborts the job.
    req_data[2*32 +: 32] = 32'h41200000;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b1010;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(resp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    check("abort_done", 32'(done_count), 32'd0);
    check("abort_data", resp_data, 32'd0);
    check("abort_id", 32'(resp_id), 32'd0);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    check("post_rst_done", 32'(done_count), 32'd1);

    // Counter wrap from a forced start value.
    preload = 1'b1;
    @(posedge clk);
    #1;
    force dut.done_count = 16'hFFFE;
    preload = 1'b0;
    #1;
    release dut.done_count;
    run_one(0, 32'h3F800000, 32'h00000001, 16'hFFFF);
    run_one(1, 32'h40000000, 32'h00000002, 16'h0000);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, limit 500000 expected");
    $fatal(1);
  end

endmodule
